// File: rtl/rrv2rvh_ruby_ld_sched_if.sv
// Tester-port / L1D load-pipe signal bundle for the Ruby load scheduler.
// The slave modport is the scheduler's view; master is the harness/driver view.
interface rrv2rvh_ruby_ld_sched_if #(
  parameter int PORT_NUM = 2,
  parameter int TAG_NUM  = 8,
  parameter int PADDR_W  = 56,
  parameter int OFFSET_W = 6
);
  localparam int TAG_W  = $clog2(TAG_NUM);
  localparam int MASK_W = 2 ** OFFSET_W;

  logic [PORT_NUM-1:0]              ruby_req_vld_i;
  logic [PORT_NUM-1:0]              ruby_req_rdy_o;
  logic [PORT_NUM-1:0][PADDR_W-1:0] ruby_req_paddr_i;
  logic [PORT_NUM-1:0][1:0]         ruby_req_size_i;
  logic [PORT_NUM-1:0]              ruby_req_unsigned_i;

  logic                             l1d_req_vld_o;
  logic                             l1d_req_rdy_i;
  logic [PADDR_W-1:0]               l1d_req_paddr_o;
  logic [MASK_W-1:0]                l1d_req_mask_o;
  logic [TAG_W-1:0]                 l1d_req_tag_o;

  logic                             l1d_resp_vld_i;
  logic [TAG_W-1:0]                 l1d_resp_tag_i;
  logic [63:0]                      l1d_resp_data_i;

  logic [PORT_NUM-1:0]              ruby_resp_vld_o;
  logic [63:0]                      ruby_resp_data_o;
  logic                             err_o;

  modport slave (
    input  ruby_req_vld_i, ruby_req_paddr_i, ruby_req_size_i, ruby_req_unsigned_i,
    output ruby_req_rdy_o,
    output l1d_req_vld_o, l1d_req_paddr_o, l1d_req_mask_o, l1d_req_tag_o,
    input  l1d_req_rdy_i,
    input  l1d_resp_vld_i, l1d_resp_tag_i, l1d_resp_data_i,
    output ruby_resp_vld_o, ruby_resp_data_o, err_o
  );

  modport master (
    output ruby_req_vld_i, ruby_req_paddr_i, ruby_req_size_i, ruby_req_unsigned_i,
    input  ruby_req_rdy_o,
    input  l1d_req_vld_o, l1d_req_paddr_o, l1d_req_mask_o, l1d_req_tag_o,
    output l1d_req_rdy_i,
    output l1d_resp_vld_i, l1d_resp_tag_i, l1d_resp_data_i,
    input  ruby_resp_vld_o, ruby_resp_data_o, err_o
  );
endinterface

// File: rtl/rrv2rvh_ruby_ld_sched.sv
// Round-robin load scheduler: tester ports -> tagged line-aligned L1D requests,
// with an outstanding-load table that routes and extends returning data.
module rrv2rvh_ruby_ld_sched #(
  parameter int PORT_NUM = 2,
  parameter int TAG_NUM  = 8,
  parameter int PADDR_W  = 56,
  parameter int OFFSET_W = 6
) (
  input logic                    clk,
  input logic                    rst_n,
  rrv2rvh_ruby_ld_sched_if.slave bus
);
  localparam int TAG_W  = $clog2(TAG_NUM);
  localparam int MASK_W = 2 ** OFFSET_W;
  localparam int PTR_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  // outstanding-load table
  logic [TAG_NUM-1:0] ent_vld_reg;
  logic [PTR_W-1:0]   ent_port_reg [TAG_NUM];
  logic [2:0]         ent_off_reg  [TAG_NUM];
  logic [1:0]         ent_size_reg [TAG_NUM];
  logic               ent_uns_reg  [TAG_NUM];
  logic [TAG_NUM-1:0] ent_set;
  logic [TAG_NUM-1:0] ent_clr;

  // output register
  logic               oreg_vld_reg;
  logic [PADDR_W-1:0] oreg_paddr_reg;
  logic [MASK_W-1:0]  oreg_mask_reg;
  logic [TAG_W-1:0]   oreg_tag_reg;

  logic [PTR_W-1:0]    rr_ptr_reg;
  logic [PORT_NUM-1:0] resp_vld_reg;
  logic [63:0]         resp_data_reg;
  logic                err_reg;

  logic               free_found;
  logic [TAG_W-1:0]   free_idx;
  logic               any_req;
  logic [PTR_W-1:0]   win_idx;
  logic               can_load;
  logic               grant;
  logic [PADDR_W-1:0] win_paddr;
  logic [1:0]         win_size;
  logic               win_uns;
  logic [MASK_W-1:0]  win_ones;
  logic [MASK_W-1:0]  win_mask;
  logic               win_misalign;

  logic [TAG_W-1:0]    resp_tag;
  logic                resp_hit;
  logic                resp_miss;
  logic [PTR_W-1:0]    r_port;
  logic [2:0]          r_off;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [63:0]         resp_shift;
  logic [63:0]         resp_ext;

  // lowest-index free entry, judged on registered state so a tag freed this
  // cycle is only reallocated next cycle
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      if (!ent_vld_reg[i]) begin
        free_found = 1'b1;
        free_idx   = TAG_W'(i);
      end
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    win_idx = '0;
    for (int k = PORT_NUM - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (bus.ruby_req_vld_i[idx]) begin
        any_req = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  assign can_load  = !oreg_vld_reg || bus.l1d_req_rdy_i;
  // gated by rst_n so ready stays low while reset is held
  assign grant     = rst_n && can_load && free_found && any_req;
  assign win_paddr = bus.ruby_req_paddr_i[win_idx];
  assign win_size  = bus.ruby_req_size_i[win_idx];
  assign win_uns   = bus.ruby_req_unsigned_i[win_idx];

  generate
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_rdy
      assign bus.ruby_req_rdy_o[gi] = grant && (win_idx == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    win_ones     = '0;
    win_misalign = 1'b0;
    case (win_size)
      2'd0: win_ones = MASK_W'(8'h01);
      2'd1: begin
        win_ones     = MASK_W'(8'h03);
        win_misalign = win_paddr[0];
      end
      2'd2: begin
        win_ones     = MASK_W'(8'h0F);
        win_misalign = |win_paddr[1:0];
      end
      default: begin
        win_ones     = MASK_W'(8'hFF);
        win_misalign = |win_paddr[2:0];
      end
    endcase
  end

  assign win_mask = win_ones << win_paddr[OFFSET_W-1:0];

  assign resp_tag  = bus.l1d_resp_tag_i;
  assign resp_hit  = bus.l1d_resp_vld_i && ent_vld_reg[resp_tag];
  assign resp_miss = bus.l1d_resp_vld_i && !ent_vld_reg[resp_tag];
  assign r_port    = ent_port_reg[resp_tag];
  assign r_off     = ent_off_reg[resp_tag];
  assign r_size    = ent_size_reg[resp_tag];
  assign r_uns     = ent_uns_reg[resp_tag];

  always_comb begin
    resp_shift = bus.l1d_resp_data_i >> {r_off, 3'b000};
    case (r_size)
      2'd0:    resp_ext = r_uns ? {56'd0, resp_shift[7:0]}  : {{56{resp_shift[7]}},  resp_shift[7:0]};
      2'd1:    resp_ext = r_uns ? {48'd0, resp_shift[15:0]} : {{48{resp_shift[15]}}, resp_shift[15:0]};
      2'd2:    resp_ext = r_uns ? {32'd0, resp_shift[31:0]} : {{32{resp_shift[31]}}, resp_shift[31:0]};
      default: resp_ext = resp_shift;
    endcase
  end

  generate
    for (genvar gi = 0; gi < TAG_NUM; gi++) begin : g_ent
      assign ent_set[gi] = grant && (free_idx == TAG_W'(gi));
      assign ent_clr[gi] = resp_hit && (resp_tag == TAG_W'(gi));
    end
  endgenerate

  // the allocated entry is always free and the responding one always valid,
  // so set and clear never target the same entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld_reg <= '0;
      for (int i = 0; i < TAG_NUM; i++) begin
        ent_port_reg[i] <= '0;
        ent_off_reg[i]  <= '0;
        ent_size_reg[i] <= '0;
        ent_uns_reg[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < TAG_NUM; i++) begin
        if (ent_set[i]) begin
          ent_vld_reg[i]  <= 1'b1;
          ent_port_reg[i] <= win_idx;
          ent_off_reg[i]  <= win_paddr[2:0];
          ent_size_reg[i] <= win_size;
          ent_uns_reg[i]  <= win_uns;
        end else if (ent_clr[i]) begin
          ent_vld_reg[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_vld_reg   <= 1'b0;
      oreg_paddr_reg <= '0;
      oreg_mask_reg  <= '0;
      oreg_tag_reg   <= '0;
      rr_ptr_reg     <= '0;
    end else if (grant) begin
      oreg_vld_reg   <= 1'b1;
      oreg_paddr_reg <= {win_paddr[PADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      oreg_mask_reg  <= win_mask;
      oreg_tag_reg   <= free_idx;
      rr_ptr_reg     <= (win_idx == PTR_W'(PORT_NUM - 1)) ? '0 : win_idx + 1'b1;
    end else if (bus.l1d_req_rdy_i) begin
      oreg_vld_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_reg  <= '0;
      resp_data_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      resp_vld_reg <= resp_hit ? (PORT_NUM'(1) << r_port) : '0;
      if (resp_hit) resp_data_reg <= resp_ext;
      err_reg <= err_reg || (grant && win_misalign) || resp_miss;
    end
  end

  assign bus.l1d_req_vld_o    = oreg_vld_reg;
  assign bus.l1d_req_paddr_o  = oreg_paddr_reg;
  assign bus.l1d_req_mask_o   = oreg_mask_reg;
  assign bus.l1d_req_tag_o    = oreg_tag_reg;
  assign bus.ruby_resp_vld_o  = resp_vld_reg;
  assign bus.ruby_resp_data_o = resp_data_reg;
  assign bus.err_o            = err_reg;
endmodule
